// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by the ALU, its bench and future ALUs
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0011,
    OP_OR  = 4'b0100,
    OP_XOR = 4'b0101,
    OP_SLT = 4'b0110,
    OP_EQ  = 4'b0111,
    OP_MUL = 4'b1000
  } op_t;
  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;
endpackage

// File: rtl/seq_mul.sv
// seq_mul: shift-add unsigned multiplier, one multiplier bit per cycle, done pulses with the final product
module seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0] cnt;
  logic busy;
  // upper half accumulates, lower half shifts the multiplier out LSB first
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? m : {WIDTH{1'b0}})};
    return {s, p[WIDTH-1:1]};
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      product <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= a;
        product <= step({{WIDTH{1'b0}}, b}, a);
        cnt     <= CW'(WIDTH-1);
        busy    <= 1'b1;
      end else if (busy) begin
        product <= step(product, mcand);
        cnt     <= cnt - 1'b1;
        busy    <= cnt != CW'(1);
        done    <= cnt == CW'(1);
      end
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready handshake; single-cycle ops plus a multi-cycle shift-add multiply
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_f,
  output logic             cout_f,
  output logic             over_f
);
  localparam int M = WIDTH-1;
  state_t state;
  logic [WIDTH:0] s_add, s_sub;
  logic ov_add, ov_sub, eqz;
  logic [WIDTH-1:0] n_res;
  logic n_z, n_c, n_o, mul_done, start;
  logic [2*WIDTH-1:0] product;
  assign start = in_ready && in_valid && op == OP_MUL;
  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .done(mul_done), .product(product)
  );
  always_comb begin
    s_add  = {1'b0, a} + {1'b0, b};
    s_sub  = {1'b0, a} + {1'b0, ~b} + 1'b1;
    ov_add = (a[M] == b[M]) && (s_add[M] != a[M]);
    ov_sub = (a[M] != b[M]) && (s_sub[M] != a[M]);
    eqz    = s_sub[M:0] == '0;
    n_res  = '0;
    n_c    = 1'b0;
    n_o    = 1'b0;
    case (op)
      OP_ADD: begin {n_c, n_res} = s_add; n_o = ov_add; end
      OP_SUB: begin {n_c, n_res} = s_sub; n_o = ov_sub; end
      OP_AND: n_res = a & b;
      OP_OR:  n_res = a | b;
      OP_XOR: n_res = a ^ b;
      OP_SLT: begin n_res = WIDTH'(s_sub[M] ^ ov_sub); n_c = s_sub[WIDTH]; n_o = ov_sub; end
      OP_EQ:  begin n_res = WIDTH'(eqz); n_c = s_sub[WIDTH]; n_o = ov_sub; end
      default: ;
    endcase
    // compares report the flags of the internal difference, not of their 0/1 result
    n_z = (op == OP_SLT || op == OP_EQ) ? eqz : n_res == '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero_f    <= 1'b0;
      cout_f    <= 1'b0;
      over_f    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          if (op == OP_MUL) state <= S_MUL;
          else begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= n_res;
            zero_f    <= n_z;
            cout_f    <= n_c;
            over_f    <= n_o;
          end
        end
        S_MUL: if (mul_done) begin
          state     <= S_DONE;
          out_valid <= 1'b1;
          result    <= product[M:0];
          zero_f    <= product[M:0] == '0;
          cout_f    <= |product[2*WIDTH-1:WIDTH];
          over_f    <= 1'b0;
        end
        S_DONE: if (out_ready) begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
